// File: rtl/adc_interface_mc_pkg.sv
// adc_pkg: shared defaults and channel-slice helper for the multi-channel ADC interface.
// Revision: 1.0
`default_nettype none

package adc_pkg;
   localparam int DATA_WIDTH_DEF    = 8;
   localparam int NUM_CH_DEF        = 2;
   localparam int CLK_DIV_WIDTH_DEF = 32;
   localparam int AVG_LOG2_MAX_DEF  = 4;
   localparam int AVG_LOG2_W        = 3;

   // LSB position of channel ch inside a packed multi-channel word
   function automatic int ch_lsb(input int ch, input int width);
      return ch * width;
   endfunction
endpackage

`default_nettype wire

// File: rtl/adc_interface_mc_if.sv
// adc_interface_mc_if: rdy/ack result channel carrying one packed word for all channels.
// Revision: 1.0
`default_nettype none

interface adc_interface_mc_if #(
   parameter int WIDTH = 16
) ();
   logic [WIDTH-1:0] SI_data;
   logic             SI_rdy;
   logic             SI_ack;
   logic             SI_ovf;

   modport master (output SI_data, output SI_rdy, output SI_ovf, input SI_ack);
   modport slave  (input SI_data, input SI_rdy, input SI_ovf, output SI_ack);
endinterface

`default_nettype wire

// File: rtl/adc_clk_div.sv
// adc_clk_div: programmable ADC sample-clock divider and sample-tick generator.
// Revision: 1.0
`default_nettype none

module adc_clk_div #(
   parameter int CLK_DIV_WIDTH = 32
) (
   input  wire logic                     clk_i,
   input  wire logic                     rst_n,
   input  wire logic [CLK_DIV_WIDTH-1:0] i_decimation_factor,
   output logic                          o_clk,
   output logic                          o_tick
);
   logic [CLK_DIV_WIDTH-1:0] r_cnt;
   logic                     r_clk_div;
   logic                     w_bypass;
   logic                     w_wrap;

   assign w_bypass = (i_decimation_factor == '0);
   // >= rather than == so a shrinking factor cannot strand the counter above its limit
   assign w_wrap   = (r_cnt >= (i_decimation_factor - CLK_DIV_WIDTH'(1)));

   always_ff @(posedge clk_i) begin
      if (!rst_n) begin
         r_cnt     <= '0;
         r_clk_div <= 1'b0;
      end else if (!w_bypass) begin
         if (w_wrap) begin
            r_cnt     <= '0;
            r_clk_div <= ~r_clk_div;
         end else begin
            r_cnt <= r_cnt + CLK_DIV_WIDTH'(1);
         end
      end
   end

   assign o_clk  = w_bypass ? clk_i : r_clk_div;
   assign o_tick = w_bypass | (w_wrap & ~r_clk_div);
endmodule

`default_nettype wire

// File: rtl/adc_interface_mc.sv
// adc_interface_mc: multi-channel ADC capture with 2^k averaging and rdy/ack output.
// Optional macro FAKE_ADC_EN replaces ADC_data with per-channel internal ramps.  Revision: 1.0
`default_nettype none

module adc_interface_mc
   import adc_pkg::*;
#(
   parameter int DATA_WIDTH    = DATA_WIDTH_DEF,
   parameter int NUM_CH        = NUM_CH_DEF,
   parameter int CLK_DIV_WIDTH = CLK_DIV_WIDTH_DEF,
   parameter int AVG_LOG2_MAX  = AVG_LOG2_MAX_DEF
) (
   input  wire logic                         clk_i,
   input  wire logic                         rst_n,
   input  wire logic [NUM_CH*DATA_WIDTH-1:0] ADC_data,
   output logic                              ADC_oe,
   output logic                              clk_o,
   input  wire logic [CLK_DIV_WIDTH-1:0]     decimation_factor,
   input  wire logic [AVG_LOG2_W-1:0]        avg_log2,
   adc_interface_mc_if.master                si
);
   localparam int ACC_W = DATA_WIDTH + AVG_LOG2_MAX;
   localparam int BLK_W = AVG_LOG2_MAX + 1;
   localparam int OUT_W = NUM_CH * DATA_WIDTH;

   logic                  w_tick;
   logic [AVG_LOG2_W-1:0] w_k_clamp;
   logic [AVG_LOG2_W-1:0] w_k_eff;
   logic [AVG_LOG2_W-1:0] r_k_lat;
   logic [BLK_W-1:0]      r_blk_cnt;
   logic [BLK_W-1:0]      w_blk_end;
   logic                  w_blk_last;
   logic [OUT_W-1:0]      w_result;
   logic [OUT_W-1:0]      r_si_data;
   logic                  r_si_rdy;
   logic                  r_si_ovf;
   logic                  r_lost;

   adc_clk_div #(
      .CLK_DIV_WIDTH (CLK_DIV_WIDTH)
   ) u_clk_div (
      .clk_i               (clk_i),
      .rst_n               (rst_n),
      .i_decimation_factor (decimation_factor),
      .o_clk               (clk_o),
      .o_tick              (w_tick)
   );

   assign ADC_oe = 1'b0;

   assign w_k_clamp = (avg_log2 > AVG_LOG2_W'(AVG_LOG2_MAX)) ? AVG_LOG2_W'(AVG_LOG2_MAX) : avg_log2;
   // The exponent is only re-read at a block boundary; mid-block it stays frozen
   assign w_k_eff    = (r_blk_cnt == '0) ? w_k_clamp : r_k_lat;
   assign w_blk_end  = (BLK_W'(1) << w_k_eff) - BLK_W'(1);
   assign w_blk_last = w_tick && (r_blk_cnt == w_blk_end);

   for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
      logic [DATA_WIDTH-1:0] w_sample;
      logic [ACC_W-1:0]      r_acc;
      logic [ACC_W-1:0]      w_sum;

`ifdef FAKE_ADC_EN
      logic [DATA_WIDTH-1:0] r_ramp;
      logic                  w_unused_adc;

      assign w_unused_adc = ^ADC_data[ch_lsb(c, DATA_WIDTH) +: DATA_WIDTH];

      always_ff @(posedge clk_i) begin
         if (!rst_n) begin
            r_ramp <= DATA_WIDTH'(c);
         end else if (w_tick) begin
            r_ramp <= r_ramp + DATA_WIDTH'(1);
         end
      end

      assign w_sample = r_ramp;
`else
      assign w_sample = ADC_data[ch_lsb(c, DATA_WIDTH) +: DATA_WIDTH];
`endif

      assign w_sum = r_acc + ACC_W'(w_sample);
      assign w_result[ch_lsb(c, DATA_WIDTH) +: DATA_WIDTH] = DATA_WIDTH'(w_sum >> w_k_eff);

      always_ff @(posedge clk_i) begin
         if (!rst_n) begin
            r_acc <= '0;
         end else if (w_tick) begin
            r_acc <= w_blk_last ? '0 : w_sum;
         end
      end
   end

   always_ff @(posedge clk_i) begin
      if (!rst_n) begin
         r_blk_cnt <= '0;
         r_k_lat   <= '0;
         r_si_data <= '0;
         r_si_rdy  <= 1'b0;
         r_si_ovf  <= 1'b0;
         r_lost    <= 1'b0;
      end else begin
         r_k_lat <= w_k_eff;
         if (w_tick) begin
            r_blk_cnt <= w_blk_last ? '0 : (r_blk_cnt + BLK_W'(1));
         end
         if (w_blk_last) begin
            if (!r_si_rdy || si.SI_ack) begin
               r_si_data <= w_result;
               r_si_rdy  <= 1'b1;
               r_si_ovf  <= r_lost;
               r_lost    <= 1'b0;
            end else begin
               r_lost <= 1'b1;
            end
         end else if (r_si_rdy && si.SI_ack) begin
            r_si_rdy <= 1'b0;
         end
      end
   end

   assign si.SI_data = r_si_data;
   assign si.SI_rdy  = r_si_rdy;
   assign si.SI_ovf  = r_si_ovf;
endmodule

`default_nettype wire

// File: tb/tb_adc_interface_mc.sv
// tb_adc_interface_mc: directed self-checking bench for adc_interface_mc (default build).
// Revision: 1.0
`default_nettype none

module tb_adc_interface_mc;
   logic        clk_i = 1'b0;
   logic        rst_n;
   logic [15:0] ADC_data;
   logic [31:0] decimation_factor;
   logic [2:0]  avg_log2;
   logic        ADC_oe;
   logic        clk_o;
   int          tests = 0;
   int          fails = 0;

   always #5 clk_i = ~clk_i;

   adc_interface_mc_if #(.WIDTH(16)) si ();

   adc_interface_mc #(
      .DATA_WIDTH    (8),
      .NUM_CH        (2),
      .CLK_DIV_WIDTH (32),
      .AVG_LOG2_MAX  (4)
   ) dut (
      .clk_i             (clk_i),
      .rst_n             (rst_n),
      .ADC_data          (ADC_data),
      .ADC_oe            (ADC_oe),
      .clk_o             (clk_o),
      .decimation_factor (decimation_factor),
      .avg_log2          (avg_log2),
      .si                (si)
   );

   // Reset with the given config; returns on the negedge where rst_n rises (state n=0)
   task automatic start(input logic [31:0] dec, input logic [2:0] k, input logic ack);
      @(negedge clk_i);
      rst_n             = 1'b0;
      decimation_factor = dec;
      avg_log2          = k;
      si.SI_ack         = ack;
      repeat (2) @(negedge clk_i);
      rst_n = 1'b1;
   endtask

   task automatic step();
      @(posedge clk_i);
      @(negedge clk_i);
   endtask

   task automatic test_reset();
      rst_n = 1'b0; decimation_factor = 32'd0; avg_log2 = 3'd0; si.SI_ack = 1'b0;
      ADC_data = 16'hA5A5;
      repeat (3) @(negedge clk_i);
      tests++; if (si.SI_rdy !== 1'b0) begin fails++; $display("FAIL reset_rdy got %b expected 0", si.SI_rdy); end
      tests++; if (si.SI_data !== 16'h0000) begin fails++; $display("FAIL reset_data got %h expected 0000", si.SI_data); end
      tests++; if (si.SI_ovf !== 1'b0) begin fails++; $display("FAIL reset_ovf got %b expected 0", si.SI_ovf); end
      tests++; if (ADC_oe !== 1'b0) begin fails++; $display("FAIL adc_oe got %b expected 0", ADC_oe); end
      tests++; if (clk_o !== 1'b0) begin fails++; $display("FAIL reset_clko_low got %b expected 0", clk_o); end
      @(posedge clk_i); #1;
      tests++; if (clk_o !== 1'b1) begin fails++; $display("FAIL reset_clko_high got %b expected 1", clk_o); end
   endtask

   task automatic test_passthrough();
      ADC_data = 16'h2211;
      start(32'd0, 3'd0, 1'b1);
      for (int n = 1; n <= 5; n++) begin
         step();
         tests++; if (si.SI_rdy !== 1'b1) begin fails++; $display("FAIL pass_rdy n=%0d got %b expected 1", n, si.SI_rdy); end
         tests++; if (si.SI_data !== 16'h2211) begin fails++; $display("FAIL pass_data n=%0d got %h expected 2211", n, si.SI_data); end
         tests++; if (si.SI_ovf !== 1'b0) begin fails++; $display("FAIL pass_ovf n=%0d got %b expected 0", n, si.SI_ovf); end
      end
      ADC_data = 16'h4433;
      step();
      tests++; if (si.SI_data !== 16'h4433) begin fails++; $display("FAIL pass_data2 got %h expected 4433", si.SI_data); end
   endtask

   task automatic test_divider();
      logic       exp_rdy;
      logic       exp_clk;
      logic [7:0] v;
      ADC_data = {8'd0, 8'h5A};
      start(32'd3, 3'd0, 1'b1);
      for (int n = 1; n <= 24; n++) begin
         step();
         exp_rdy = (n % 6 == 3);
         exp_clk = ((n / 3) % 2 == 1);
         tests++; if (clk_o !== exp_clk) begin fails++; $display("FAIL div_clko n=%0d got %b expected %b", n, clk_o, exp_clk); end
         tests++; if (si.SI_rdy !== exp_rdy) begin fails++; $display("FAIL div_rdy n=%0d got %b expected %b", n, si.SI_rdy, exp_rdy); end
         if (exp_rdy) begin
            v = 8'(n - 1);
            tests++; if (si.SI_data !== {v, v ^ 8'h5A}) begin fails++; $display("FAIL div_data n=%0d got %h expected %h", n, si.SI_data, {v, v ^ 8'h5A}); end
         end
         v = 8'(n);
         ADC_data = {v, v ^ 8'h5A};
      end
   endtask

   task automatic test_average();
      logic        exp_rdy;
      logic [15:0] exp_data;
      int          p;
      ADC_data = {8'd200, 8'd10};
      start(32'd1, 3'd2, 1'b1);
      for (int n = 1; n <= 16; n++) begin
         step();
         exp_rdy = (n == 7) || (n >= 9 && n % 2 == 1);
         tests++; if (si.SI_rdy !== exp_rdy) begin fails++; $display("FAIL avg_rdy n=%0d got %b expected %b", n, si.SI_rdy, exp_rdy); end
         if (exp_rdy) begin
            p = ((n - 1) / 2) % 4;
            exp_data = (n == 7) ? 16'hC90B : {8'(200 + p), 8'(10 + p)};
            tests++; if (si.SI_data !== exp_data) begin fails++; $display("FAIL avg_data n=%0d got %h expected %h", n, si.SI_data, exp_data); end
         end
         if (n == 3) avg_log2 = 3'd0;
         p = (n / 2) % 4;
         ADC_data = {8'(200 + p), 8'(10 + p)};
      end
   endtask

   task automatic test_clamp();
      logic exp_rdy;
      ADC_data = 16'h0302;
      start(32'd0, 3'd7, 1'b1);
      for (int n = 1; n <= 17; n++) begin
         step();
         exp_rdy = (n == 16);
         tests++; if (si.SI_rdy !== exp_rdy) begin fails++; $display("FAIL clamp_rdy n=%0d got %b expected %b", n, si.SI_rdy, exp_rdy); end
         if (exp_rdy) begin
            tests++; if (si.SI_data !== 16'h0302) begin fails++; $display("FAIL clamp_data got %h expected 0302", si.SI_data); end
         end
      end
   endtask

   task automatic test_overflow();
      logic [15:0] exp_data;
      logic        exp_ovf;
      ADC_data = {8'h30, 8'h00};
      start(32'd0, 3'd0, 1'b0);
      for (int n = 1; n <= 6; n++) begin
         step();
         if (n <= 4) begin exp_data = 16'h3000; exp_ovf = 1'b0; end
         else begin exp_data = {8'(8'h30 + n - 1), 8'(n - 1)}; exp_ovf = (n == 5); end
         tests++; if (si.SI_rdy !== 1'b1) begin fails++; $display("FAIL ovf_rdy n=%0d got %b expected 1", n, si.SI_rdy); end
         tests++; if (si.SI_data !== exp_data) begin fails++; $display("FAIL ovf_data n=%0d got %h expected %h", n, si.SI_data, exp_data); end
         tests++; if (si.SI_ovf !== exp_ovf) begin fails++; $display("FAIL ovf_flag n=%0d got %b expected %b", n, si.SI_ovf, exp_ovf); end
         ADC_data = {8'(8'h30 + n), 8'(n)};
         if (n == 4) si.SI_ack = 1'b1;
      end
   endtask

   task automatic test_factor_change();
      logic exp_rdy;
      logic exp_clk;
      ADC_data = 16'hBEEF;
      start(32'd10, 3'd0, 1'b1);
      for (int n = 1; n <= 17; n++) begin
         step();
         exp_clk = (n < 8) ? 1'b0 : (((n - 8) / 2) % 2 == 0);
         exp_rdy = (n == 8) || (n == 12) || (n == 16);
         tests++; if (clk_o !== exp_clk) begin fails++; $display("FAIL fc_clko n=%0d got %b expected %b", n, clk_o, exp_clk); end
         tests++; if (si.SI_rdy !== exp_rdy) begin fails++; $display("FAIL fc_rdy n=%0d got %b expected %b", n, si.SI_rdy, exp_rdy); end
         if (n == 8) begin
            tests++; if (si.SI_data !== 16'hBEEF) begin fails++; $display("FAIL fc_data got %h expected beef", si.SI_data); end
         end
         if (n == 7) decimation_factor = 32'd2;
      end
   endtask

   task automatic test_midblock_reset();
      logic exp_rdy;
      ADC_data = 16'h5555;
      start(32'd0, 3'd0, 1'b0);
      repeat (3) step();
      avg_log2  = 3'd3;
      si.SI_ack = 1'b1;
      repeat (3) step();
      rst_n = 1'b0;
      step();
      tests++; if (si.SI_rdy !== 1'b0) begin fails++; $display("FAIL mrst_rdy got %b expected 0", si.SI_rdy); end
      tests++; if (si.SI_data !== 16'h0000) begin fails++; $display("FAIL mrst_data got %h expected 0000", si.SI_data); end
      tests++; if (si.SI_ovf !== 1'b0) begin fails++; $display("FAIL mrst_ovf got %b expected 0", si.SI_ovf); end
      ADC_data = 16'h2010;
      step();
      rst_n = 1'b1;
      for (int n = 1; n <= 9; n++) begin
         step();
         exp_rdy = (n == 8);
         tests++; if (si.SI_rdy !== exp_rdy) begin fails++; $display("FAIL mrst_blk_rdy n=%0d got %b expected %b", n, si.SI_rdy, exp_rdy); end
         if (exp_rdy) begin
            tests++; if (si.SI_data !== 16'h2010) begin fails++; $display("FAIL mrst_blk_data got %h expected 2010", si.SI_data); end
            tests++; if (si.SI_ovf !== 1'b0) begin fails++; $display("FAIL mrst_blk_ovf got %b expected 0", si.SI_ovf); end
         end
      end
   endtask

   initial begin
      test_reset();
      test_passthrough();
      test_divider();
      test_average();
      test_clamp();
      test_overflow();
      test_factor_change();
      test_midblock_reset();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule

`default_nettype wire

// File: doc/adc_interface_mc.md
# adc_interface_mc

Multi-channel successor to the single-ADC interface. Drives a shared ADC sample clock at a programmable division of the FPGA clock, captures NUM_CH parallel ADC words on each sample tick, and optionally averages 2^k consecutive samples per channel. Delivers one packed word covering all channels over the simple rdy/ack interface, and flags results lost to back-pressure. Sits between the ADC pins and the acquisition buffer/trigger logic.

## Interface
- DATA_WIDTH, 8: bits per ADC channel.
- NUM_CH, 2: number of ADC channels sampled simultaneously.
- CLK_DIV_WIDTH, 32: width of decimation_factor and the divider counter.
- AVG_LOG2_MAX, 4: maximum averaging exponent; accumulator width is DATA_WIDTH+AVG_LOG2_MAX.

- clk_i  in  1  FPGA clock; every flop is on its rising edge.
- rst_n  in  1  reset, synchronous, active-low.
- ADC_data  in  NUM_CH*DATA_WIDTH  ADC outputs; channel c occupies bits [c*DATA_WIDTH +: DATA_WIDTH].
- ADC_oe  out  1  ADC output enable, active-low, constant 0.
- clk_o  out  1  ADC sample clock.
- SI_data  out  NUM_CH*DATA_WIDTH  result word, same packing as ADC_data.
- SI_rdy  out  1  SI_data valid.
- SI_ack  in  1  consumer accepts SI_data.
- SI_ovf  out  1  at least one result was dropped before the current SI_data; valid with SI_rdy.
- decimation_factor  in  CLK_DIV_WIDTH  0: clk_o = clk_i; N>0: clk_o period = 2N clk_i cycles.
- avg_log2  in  3  averaging exponent k; 2^k samples per result; values above AVG_LOG2_MAX clamp to AVG_LOG2_MAX.

## Operation
- Divider: decimation_factor==0 makes clk_o a combinational copy of clk_i, and the tick fires every cycle. Otherwise the counter increments each cycle. When counter >= decimation_factor-1, counter goes to 0 and clk_div toggles. The >= comparison recovers from a factor decrease mid-run within one cycle. clk_o = clk_div.
- Tick: decimation_factor==0, or (counter >= decimation_factor-1 and clk_div==0), i.e. the cycle before the clk_o rising edge. ADC_data is captured on the tick.
- Averaging: k_lat is latched from the clamped avg_log2 when blk_cnt==0. Each tick adds every channel sample to acc[c] and increments blk_cnt. On the 2^k_lat-th tick, the result per channel is (acc[c]+sample)>>k_lat, truncated. acc and blk_cnt then clear. With k=0, every tick produces a result.
- Output handshake: a result loads into SI_data when SI_rdy==0 or SI_ack==1 in that cycle. On load, SI_rdy<=1 and SI_ovf<=lost, then lost<=0.
- If SI_rdy==1 and SI_ack==0 when a result completes, the result is discarded and lost<=1. SI_data holds.
- SI_ack with SI_rdy and no new result: SI_rdy<=0. SI_ack while SI_rdy==0 is ignored.
- Reset values: counter 0, clk_div 0, acc 0, blk_cnt 0, k_lat 0, lost 0, SI_rdy 0, SI_data 0, SI_ovf 0.
- clk_o with decimation_factor==0 follows clk_i even during reset.

## Timing
- Result latency: SI_rdy rises on the clk_i edge that closes the final tick of the block, 1 cycle after that tick's capture.
- Back-to-back: ack and new result in the same cycle keep SI_rdy high with the new data, with no bubble.
- Throughput, decimation_factor=N>0: one result per 2N·2^k clk_i cycles. For N=0: one result per 2^k cycles.
- Reset mid-block discards the partial accumulation. The first tick after release starts a new block.
- Config changes take effect as follows. decimation_factor: next cycle. avg_log2: next block boundary only.

## Configuration
- FAKE_ADC_EN defined: ADC_data is ignored. Channel c uses an internal DATA_WIDTH-bit ramp that resets to c and increments by 1 on each tick, wrapping at 2^DATA_WIDTH. ADC_oe stays 0. No ROM file is needed.
- FAKE_ADC_EN undefined: ADC_data is sampled. No ramp logic is synthesised.

## Structure
- Shared package adc_pkg holds:
  - default DATA_WIDTH, CLK_DIV_WIDTH and AVG_LOG2_MAX constants;
  - AVG_LOG2_W=3;
  - the channel-slice helper constant/function used by the acquisition path.
- Sub-module adc_clk_div contains the divider counter, clk_div, the clk_o mux and tick generation. The top level holds the accumulators, block counter, output register and fake-ramp generator.

## Test plan
- decimation_factor=0, k=0, ADC_data={8'h22,8'h11}, SI_ack=1 → SI_rdy high continuously from the 2nd cycle after reset release, SI_data=16'h2211, SI_ovf=0.
- decimation_factor=3, k=0 → clk_o period 6 cycles, 50% duty; one result per 6 cycles, captured the cycle before each clk_o rising edge.
- decimation_factor=1, k=2, channel 0 fed 10,11,12,13 on successive ticks → one result per 8 cycles, channel 0 = 11 (46>>2).
- SI_ack held 0, decimation_factor=0, k=0 → first word held. After ack, the next word has SI_ovf=1 and the word after it has SI_ovf=0.
- decimation_factor changed 10→2 while counter=7 → counter wraps on the next cycle, then the clk_o period is 4 cycles. rst_n low mid-block → all outputs return to their reset values.
- FAKE_ADC_EN, NUM_CH=2, decimation_factor=0, k=0 → SI_data sequence {1,0},{2,1},{3,2}…, wrapping channel 1 from 255 to 0.
